uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baudgen.sv | 42 ++++
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample ratio, parity modes and TX state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 8;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_DONE
    } tx_state_e;

endpackage

// File: rtl/uart_baudgen.sv
// Fractional phase accumulator: tick_o is the carry out of acc + Incr, giving
// an average tick rate of f_clk * Incr / 2^Width.
module uart_baudgen #(
    parameter int Width = 10,
    parameter int Incr  = 78
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [Width:0] IncrW = Incr[Width:0];

    logic [Width-1:0] acc_q, acc_d;
    logic [Width:0]   sum;

    assign sum    = {1'b0, acc_q} + IncrW;
    assign tick_o = en_i & sum[Width];

    // Clear wins over enable so a new frame always starts from phase zero.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum[Width-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would create order-dependent races between flops in simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per level send/done handshake, LSB first,
// optional parity and second stop bit, all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int Width    = 10,
    parameter int Incr     = 78,
    parameter int Parity   = PAR_NONE,
    parameter int StopBits = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       send,
    output logic       done,
    output logic       busy,
    output logic       rout
);

    tx_state_e         state_q, state_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              par_q, par_d;
    logic              rout_q, rout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic baud_clr;
    logic baud_en;
    logic tick;
    logic bit_end;
    logic par_final;

    assign baud_clr = (state_q == TX_IDLE) && send;
    assign baud_en  = (state_q != TX_IDLE) && (state_q != TX_DONE);
    assign bit_end  = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

    // Parity including the data bit being shifted out this cycle.
    assign par_final = (Parity == PAR_ODD) ? ~(par_q ^ shreg_q[0]) : (par_q ^ shreg_q[0]);

    uart_baudgen #(
        .Width (Width),
        .Incr  (Incr)
    ) u_baudgen (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (baud_clr),
        .en_i   (baud_en),
        .tick_o (tick)
    );

    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        tick_cnt_d = tick_cnt_q;
        par_d      = par_q;
        rout_d     = rout_q;
        busy_d     = busy_q;
        done_d     = done_q;

        if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            TX_IDLE: begin
                if (send) begin
                    shreg_d    = din;
                    bit_idx_d  = '0;
                    tick_cnt_d = '0;
                    par_d      = 1'b0;
                    rout_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    rout_d  = shreg_q[0];
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    par_d     = par_q ^ shreg_q[0];
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        if (Parity != PAR_NONE) begin
                            rout_d  = par_final;
                            state_d = TX_PARITY;
                        end else begin
                            rout_d  = 1'b1;
                            state_d = TX_STOP;
                        end
                    end else begin
                        rout_d = shreg_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    rout_d    = 1'b1;
                    bit_idx_d = '0;
                    state_d   = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(StopBits - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = TX_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            TX_DONE: begin
                // Held send keeps us here: a new frame needs send seen low first.
                if (!send) begin
                    done_d  = 1'b0;
                    state_d = TX_IDLE;
                end
            end
            default: begin
                rout_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            tick_cnt_q <= '0;
            par_q      <= 1'b0;
            rout_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            tick_cnt_q <= tick_cnt_d;
            par_q      <= par_d;
            rout_q     <= rout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rout = rout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five parameterisations share one stimulus stream, each
// checked against an expected bit list or a 115200-baud sampling receiver.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       send;
    logic [4:0] done_v;
    logic [4:0] busy_v;
    logic [4:0] rout_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2 (all 16 clk/bit); 4: defaults 8N1
    uart_tx #(.Width(4), .Incr(8), .Parity(0), .StopBits(1)) u_n1 (
        .clk(clk), .reset(reset), .din(din), .send(send),
        .done(done_v[0]), .busy(busy_v[0]), .rout(rout_v[0]));
    uart_tx #(.Width(4), .Incr(8), .Parity(2), .StopBits(1)) u_e1 (
        .clk(clk), .reset(reset), .din(din), .send(send),
        .done(done_v[1]), .busy(busy_v[1]), .rout(rout_v[1]));
    uart_tx #(.Width(4), .Incr(8), .Parity(1), .StopBits(1)) u_o1 (
        .clk(clk), .reset(reset), .din(din), .send(send),
        .done(done_v[2]), .busy(busy_v[2]), .rout(rout_v[2]));
    uart_tx #(.Width(4), .Incr(8), .Parity(0), .StopBits(2)) u_n2 (
        .clk(clk), .reset(reset), .din(din), .send(send),
        .done(done_v[3]), .busy(busy_v[3]), .rout(rout_v[3]));
    uart_tx u_def (
        .clk(clk), .reset(reset), .din(din), .send(send),
        .done(done_v[4]), .busy(busy_v[4]), .rout(rout_v[4]));

    typedef struct {
        logic [7:0] din;
        logic       exp_even;
        logic       exp_odd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Fixed 16 clk/bit instance: first sample is the negedge after acceptance.
    task automatic chk_fixed(input int idx, input logic [7:0] d, input int par,
                             input int nstop, input logic pbit, input bit dropped);
        logic bits[$];
        logic [15:0] line;
        bit ok;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (par != 0) bits.push_back(pbit);
        for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++) begin
            ok = 1'b1;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                line[c] = rout_v[idx];
                if (!busy_v[idx] || done_v[idx]) ok = 1'b0;
            end
            check($sformatf("i%0d_bit%0d_line", idx, k), line, {16{bits[k]}});
            check($sformatf("i%0d_bit%0d_busy", idx, k), 32'(ok), 32'd1);
        end
        @(negedge clk);
        check($sformatf("i%0d_end_done_busy_rout", idx),
              {done_v[idx], busy_v[idx], rout_v[idx]}, 3'b101);
        if (dropped) begin
            @(negedge clk);
            check($sformatf("i%0d_done_pulse", idx), done_v[idx], 1'b0);
        end
    endtask

    // Default instance: sampled like a 115200-baud receiver on a 12 MHz clock.
    task automatic chk_def(input logic [7:0] d, input bit dropped);
        int len = -1;
        int t_rise = -1;
        int t_fall = -1;
        int k = 0;
        logic [9:0] rx = '0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (k < 10 && i == ((2 * k + 1) * 625) / 12) begin
                rx[k] = rout_v[4];
                k++;
            end
            if (t_rise < 0 && rout_v[4]) t_rise = i;
            else if (t_rise >= 0 && t_fall < 0 && !rout_v[4]) t_fall = i;
            if (!busy_v[4]) begin
                len = i;
                break;
            end
        end
        check("def_frame_len_ok", 32'(len >= 1050 && len <= 1051), 32'd1);
        check("def_done_at_end", done_v[4], 1'b1);
        check("def_rx_frame", rx, {1'b1, d, 1'b0});
        if (d[1:0] == 2'b01) begin
            check("def_start_len_ok", 32'(t_rise >= 105 && t_rise <= 106), 32'd1);
            check("def_d0_len_ok", 32'(t_fall - t_rise >= 105 && t_fall - t_rise <= 106), 32'd1);
        end
        if (dropped) begin
            @(negedge clk);
            check("def_done_pulse", done_v[4], 1'b0);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic pe, input logic po,
                             input bit drop_mid, input bit change_din, input int hold);
        bit ok;
        @(negedge clk);
        din  = d;
        send = 1'b1;
        @(posedge clk);
        fork
            chk_fixed(0, d, 0, 1, 1'b0, drop_mid);
            chk_fixed(1, d, 2, 1, pe, drop_mid);
            chk_fixed(2, d, 1, 1, po, drop_mid);
            chk_fixed(3, d, 0, 2, 1'b0, drop_mid);
            chk_def(d, drop_mid);
            begin
                if (drop_mid) begin
                    repeat (20) @(negedge clk);
                    send = 1'b0;
                end
            end
            begin
                if (change_din) begin
                    repeat (2) @(negedge clk);
                    din = 8'hFF;
                end
            end
        join
        if (!drop_mid) begin
            check("done_held", done_v, 5'h1f);
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (busy_v != 5'h00 || done_v != 5'h1f || rout_v != 5'h1f) ok = 1'b0;
            end
            if (hold > 0) check("no_retrigger_on_held_send", 32'(ok), 32'd1);
            @(negedge clk);
            send = 1'b0;
            @(negedge clk);
            check("done_release", done_v, 5'h00);
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        logic [7:0] rd;
        logic rpe;
        bit idle_ok;

        tbl[0] = '{din: 8'h55, exp_even: 1'b0, exp_odd: 1'b1};
        tbl[1] = '{din: 8'h07, exp_even: 1'b1, exp_odd: 1'b0};
        tbl[2] = '{din: 8'h41, exp_even: 1'b0, exp_odd: 1'b1};
        tbl[3] = '{din: 8'h80, exp_even: 1'b1, exp_odd: 1'b0};

        reset = 1'b1;
        send  = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rout_v, busy_v, done_v}, {5'h1f, 5'h00, 5'h00});
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {rout_v, busy_v, done_v}, {5'h1f, 5'h00, 5'h00});

        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].din, tbl[i].exp_even, tbl[i].exp_odd, 1'b0, 1'b0, 0);
        end

        // Held send for 500 clk after done, then a second frame after release.
        run_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 500);
        run_frame(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // din changes after acceptance must not reach the line.
        run_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0);

        // send dropped mid-frame: frame completes, done pulses for one cycle.
        run_frame(8'hC9, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            rd  = 8'($urandom_range(0, 255));
            rpe = ($countones(rd) % 2) == 1;
            run_frame(rd, rpe, ~rpe, 1'b0, 1'b0, 0);
        end

        // Reset during data bit 4 of the 16 clk/bit instances.
        @(negedge clk);
        din  = 8'hFF;
        send = 1'b1;
        @(posedge clk);
        repeat (86) @(negedge clk);
        check("mid_frame_busy", busy_v[0], 1'b1);
        reset = 1'b1;
        send  = 1'b0;
        @(negedge clk);
        check("reset_mid_frame", {rout_v, busy_v, done_v}, {5'h1f, 5'h00, 5'h00});
        reset = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rout_v != 5'h1f || busy_v != 5'h00 || done_v != 5'h00) idle_ok = 1'b0;
        end
        check("idle_after_reset", 32'(idle_ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
